// File: rtl/rx_fifo_buffer.sv
// DEPTH-entry circular buffer between the RX async FIFO read side and the lane collector.
// Optional feature: define RX_FIFO_BUFFER_SYNC_CNT_EN to add the saturating sync_count output.
module rx_fifo_buffer #(
    parameter int WR_WIDTH = 48,
    parameter int DEPTH    = 4,
    parameter int LANES    = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_enable,
    input  logic                      canpop_fifo,
    output logic                      pop_fifo,
    input  logic [WR_WIDTH-1:0]       data_fifo,
    input  logic                      data_valid_fifo,
    output logic                      canpop_collector,
    input  logic                      pop_collector,
    output logic [WR_WIDTH-2:0]       data_collector,
    output logic                      data_valid_collector,
    output logic                      issync_collector,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic [LANES-1:0]          out_blocklock_remote,
    output logic                      out_blocklock_remote_en
`ifdef RX_FIFO_BUFFER_SYNC_CNT_EN
    ,
    output logic [15:0]               sync_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    logic [WR_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic                pend_r;
    logic                overflow_r;
    logic [LANES-1:0]    blr_r;
    logic                blr_en_r;

    logic                act_s;
    logic                nempty_s;
    logic                full_s;
    logic                cpop_s;
    logic                wr_s;
    logic                drop_s;
    logic                sync_pop_s;
    logic [WR_WIDTH-1:0] head_s;
    logic [CNT_W:0]      commit_s;

    // Reset gates every request so nothing is popped while the buffer is being cleared.
    assign act_s      = in_enable & ~reset;
    assign head_s     = mem_r[rd_ptr_r];
    assign nempty_s   = (count_r != {CNT_W{1'b0}});
    assign full_s     = (count_r == FULL_C);
    assign cpop_s     = act_s & pop_collector & nempty_s;
    assign wr_s       = act_s & data_valid_fifo & (~full_s | cpop_s);
    assign drop_s     = act_s & data_valid_fifo & full_s & ~cpop_s;
    assign sync_pop_s = cpop_s & head_s[WR_WIDTH-1];

    // Committed occupancy includes the word already requested but not yet returned.
    assign commit_s = {1'b0, count_r} + {{CNT_W{1'b0}}, pend_r} - {{CNT_W{1'b0}}, cpop_s};
    assign pop_fifo = act_s & canpop_fifo & (commit_s < {1'b0, FULL_C});

    assign canpop_collector        = nempty_s;
    assign data_collector          = head_s[WR_WIDTH-2:0];
    assign issync_collector        = head_s[WR_WIDTH-1] & nempty_s;
    assign data_valid_collector    = cpop_s;
    assign level                   = count_r;
    assign overflow                = overflow_r;
    assign out_blocklock_remote    = blr_r;
    assign out_blocklock_remote_en = blr_en_r;

    // Storage array write port; no reset needed since count_r qualifies every read.
    always_ff @(posedge clock) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= data_fifo;
        end
    end

    // Pointers, occupancy, pending-read tracking, overflow flag and sync extraction.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            pend_r     <= 1'b0;
            overflow_r <= 1'b0;
            blr_r      <= {LANES{1'b1}};
            blr_en_r   <= 1'b0;
        end else if (in_enable) begin
            pend_r <= pop_fifo;
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (cpop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + {{PTR_W{1'b0}}, wr_s} - {{PTR_W{1'b0}}, cpop_s};
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            if (sync_pop_s) begin
                blr_r <= head_s[LANES-1:0];
            end
            blr_en_r <= sync_pop_s;
        end else begin
            blr_en_r <= 1'b0;
        end
    end

`ifdef RX_FIFO_BUFFER_SYNC_CNT_EN
    logic [15:0] sync_count_r;

    // Saturating count of consumed sync words.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_count_r <= 16'h0000;
        end else if (sync_pop_s && (sync_count_r != 16'hFFFF)) begin
            sync_count_r <= sync_count_r + 16'h0001;
        end else begin
            sync_count_r <= sync_count_r;
        end
    end

    assign sync_count = sync_count_r;
`endif

endmodule
